shift_driver: RTL



---
 rtl/shift_driver_pkg.sv | 31 +++
 rtl/shift_driver_cnt.sv | 40 ++++
 rtl/shift_driver.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/shift_driver_pkg.sv
// Shared encodings for shift_driver: operation modes, FSM states and the strobe bundle.
// Pure declarations; no logic, no latency.
package shift_driver_pkg;

  localparam logic [1:0] MODE_LOAD  = 2'b00;
  localparam logic [1:0] MODE_SHR   = 2'b01;
  localparam logic [1:0] MODE_SHL   = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRECLR = 2'd1,
    SHIFT  = 2'd2,
    FIN    = 2'd3
  } state_t;

  // Control strobes and serial bits presented to the target register.
  typedef struct packed {
    logic cl;
    logic ld;
    logic sr;
    logic sl;
    logic ir;
    logic il;
  } strb_t;

  function automatic logic is_shift_mode(input logic [1:0] m);
    return (m == MODE_SHR) || (m == MODE_SHL);
  endfunction

endpackage

// File: rtl/shift_driver_cnt.sv
// Loadable down counter holding the remaining shift strobes; registered count, flags are combinational.
// Load wins over decrement; decrement saturates at zero, so no backpressure is needed.
module shift_driver_cnt
  import shift_driver_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign zero = (cnt_q == '0);
  assign last = (cnt_q == WIDTH'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && !zero) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_driver.sv
// Sequences clear/load/serial-shift strobes for a register; first strobe 1 cycle after start, done after the last.
// start is only taken while busy=0 (never queued); SHIFT_DRIVER_PRECLR_EN inserts a clear cycle before every shift.
module shift_driver
  import shift_driver_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  reg_cl,
  output logic                  reg_ld,
  output logic                  reg_sr,
  output logic                  reg_sl,
  output logic                  reg_ir,
  output logic                  reg_il,
  output logic [DATA_WIDTH-1:0] reg_in
);

  localparam logic [LEN_WIDTH-1:0] LEN_FULL = LEN_WIDTH'(DATA_WIDTH);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  shl_q, shl_d;
  strb_t                 strb_q, strb_d;
  logic [DATA_WIDTH-1:0] in_q, in_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  cnt_load;
  logic [LEN_WIDTH-1:0]  cnt_val;
  logic                  cnt_dec;
  logic                  cnt_zero;
  logic                  cnt_last;

  logic [LEN_WIDTH-1:0]  len_eff;
  logic                  start_shl;
  logic [DATA_WIDTH-1:0] start_buf;
  logic [DATA_WIDTH-1:0] emit_src;
  logic                  emit_shl;
  logic                  emit_bit;
  logic [DATA_WIDTH-1:0] emit_nxt;
  strb_t                 emit_strb;

  assign len_eff   = ((len == '0) || (len > LEN_FULL)) ? LEN_FULL : len;
  assign start_shl = (mode == MODE_SHL);
  // Left shifts are pre-aligned so the field MSB sits at the buffer MSB; every
  // left strobe then just takes the top bit, with no stored length needed.
  assign start_buf = start_shl ? (data_in << (LEN_FULL - len_eff)) : data_in;

  assign emit_src = (state_q == IDLE) ? start_buf : buf_q;
  assign emit_shl = (state_q == IDLE) ? start_shl : shl_q;
  assign emit_bit = emit_shl ? emit_src[DATA_WIDTH-1] : emit_src[0];
  assign emit_nxt = emit_shl ? {emit_src[DATA_WIDTH-2:0], 1'b0}
                             : {1'b0, emit_src[DATA_WIDTH-1:1]};

  always_comb begin
    emit_strb    = '0;
    emit_strb.sr = !emit_shl;
    emit_strb.ir = !emit_shl && emit_bit;
    emit_strb.sl = emit_shl;
    emit_strb.il = emit_shl && emit_bit;
  end

  shift_driver_cnt #(
    .WIDTH (LEN_WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  // Outputs are registered on the transition, so state_q names the state whose
  // exit produces the next cycle's strobes.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    shl_d    = shl_q;
    strb_d   = '0;
    in_d     = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          shl_d  = start_shl;
          case (mode)
            MODE_LOAD: begin
              strb_d.ld = 1'b1;
              in_d      = data_in;
              state_d   = FIN;
            end
            MODE_CLEAR: begin
              strb_d.cl = 1'b1;
              state_d   = FIN;
            end
            default: begin
              cnt_load = is_shift_mode(mode);
`ifdef SHIFT_DRIVER_PRECLR_EN
              strb_d.cl = 1'b1;
              buf_d     = start_buf;
              cnt_val   = len_eff;
              state_d   = PRECLR;
`else
              strb_d  = emit_strb;
              buf_d   = emit_nxt;
              cnt_val = len_eff - LEN_WIDTH'(1);
              state_d = (len_eff == LEN_WIDTH'(1)) ? FIN : SHIFT;
`endif
            end
          endcase
        end
      end
`ifdef SHIFT_DRIVER_PRECLR_EN
      PRECLR: begin
        busy_d  = 1'b1;
        strb_d  = emit_strb;
        buf_d   = emit_nxt;
        cnt_dec = 1'b1;
        state_d = cnt_last ? FIN : SHIFT;
      end
`endif
      SHIFT: begin
        busy_d  = 1'b1;
        strb_d  = emit_strb;
        buf_d   = emit_nxt;
        cnt_dec = 1'b1;
        state_d = (cnt_last || cnt_zero) ? FIN : SHIFT;
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      shl_q   <= 1'b0;
      strb_q  <= '0;
      in_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      shl_q   <= shl_d;
      strb_q  <= strb_d;
      in_q    <= in_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign reg_cl = strb_q.cl;
  assign reg_ld = strb_q.ld;
  assign reg_sr = strb_q.sr;
  assign reg_sl = strb_q.sl;
  assign reg_ir = strb_q.ir;
  assign reg_il = strb_q.il;
  assign reg_in = in_q;

endmodule
